// File: rtl/rgb_decoder_if.sv
// Pixel-in / decoded-colour-out handshake bundle for rgb_decoder.
// The slave modport is the decoder's view; master is the producer/consumer side.
interface rgb_decoder_if;
    logic        enable;
    logic        in_valid;
    logic [23:0] in_rgb;
    logic        in_ready;
    logic        out_valid;
    logic [2:0]  out_colour;
    logic        out_exact;
    logic        out_ready;
    logic [7:0]  miss_count;

    modport slave (
        input  enable,
        input  in_valid,
        input  in_rgb,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_colour,
        output out_exact,
        output miss_count
    );

    modport master (
        output enable,
        output in_valid,
        output in_rgb,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_colour,
        input  out_exact,
        input  miss_count
    );
endinterface

// File: rtl/rgb_decoder.sv
// Thresholds 24-bit RGB pixels to a 3-bit palette index through a 2-entry output FIFO.
// Define DROP_INEXACT_EN to count-and-discard non-palette pixels instead of passing them on.
module rgb_decoder (
    input  logic         clk,
    input  logic         rst_n,
    rgb_decoder_if.slave bus
);
    localparam int unsigned Depth = 2;

    logic [2:0] colour_q [Depth];
    logic [2:0] colour_d [Depth];
`ifndef DROP_INEXACT_EN
    logic       exact_q  [Depth];
    logic       exact_d  [Depth];
`endif
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;
    logic [7:0] miss_q, miss_d;
    // Holds in_ready low for the first cycle after reset is released.
    logic       alive_q;

    logic [7:0] chan_r, chan_g, chan_b;
    logic [2:0] pix_colour;
    logic       pix_exact;
    logic       accept, push, pop;

    assign chan_r = bus.in_rgb[23:16];
    assign chan_g = bus.in_rgb[15:8];
    assign chan_b = bus.in_rgb[7:0];

    assign pix_colour = {chan_r[7], chan_g[7], chan_b[7]};
    assign pix_exact  = ((chan_r == 8'h00) || (chan_r == 8'hFF)) &&
                        ((chan_g == 8'h00) || (chan_g == 8'hFF)) &&
                        ((chan_b == 8'h00) || (chan_b == 8'hFF));

    assign accept = bus.in_valid && bus.in_ready;
`ifdef DROP_INEXACT_EN
    assign push   = accept && pix_exact;
`else
    assign push   = accept;
`endif
    assign pop    = bus.out_valid && bus.out_ready;

    always_comb begin
        colour_d = colour_q;
`ifndef DROP_INEXACT_EN
        exact_d  = exact_q;
`endif
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        miss_d   = miss_q;

        if (push) begin
            colour_d[wr_ptr_q] = pix_colour;
`ifndef DROP_INEXACT_EN
            exact_d[wr_ptr_q]  = pix_exact;
`endif
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end

        if (accept && !pix_exact && (miss_q != 8'hFF)) begin
            miss_d = miss_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                colour_q[i] <= 3'b000;
`ifndef DROP_INEXACT_EN
                exact_q[i]  <= 1'b0;
`endif
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            miss_q   <= 8'h00;
            alive_q  <= 1'b0;
        end else begin
            colour_q <= colour_d;
`ifndef DROP_INEXACT_EN
            exact_q  <= exact_d;
`endif
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            miss_q   <= miss_d;
            alive_q  <= 1'b1;
        end
    end

    // Registered state only: no path from out_ready or in_valid into in_ready.
    assign bus.in_ready   = alive_q && bus.enable && (count_q != 2'd2);
    assign bus.out_valid  = (count_q != 2'd0);
    assign bus.out_colour = colour_q[rd_ptr_q];
`ifdef DROP_INEXACT_EN
    assign bus.out_exact  = 1'b1;
`else
    assign bus.out_exact  = exact_q[rd_ptr_q];
`endif
    assign bus.miss_count = miss_q;
endmodule

// File: doc/rgb_decoder.md
RGB_DECODER -- requirements
Module: rgb_decoder

Interface
REQ-001 Ports SHALL be (clock and reset first):
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- enable  input  1  acceptance enable; low blocks new pixels, output side keeps draining.
- in_valid  input  1  in_rgb holds a pixel.
- in_rgb  input  24  pixel {R[23:16], G[15:8], B[7:0]}.
- in_ready  output  1  decoder can accept a pixel this cycle.
- out_valid  output  1  out_colour/out_exact hold a decoded pixel.
- out_colour  output  3  decoded colour index {R,G,B}.
- out_exact  output  1  pixel was an exact palette entry.
- out_ready  input  1  consumer takes the output this cycle.
- miss_count  output  8  saturating count of non-exact pixels accepted.
REQ-002 Reset SHALL be synchronous and active-low, on port rst_n, with the single clock clk.

Function
REQ-003 A pixel SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-004 The palette SHALL be: 0=000000, 1=0000FF, 2=00FF00, 3=00FFFF, 4=FF0000, 5=FF00FF, 6=FFFF00, 7=FFFFFF.
REQ-005 Decoding SHALL be out_colour={R[7],G[7],B[7]}, i.e. each channel thresholded at 8'd128.
REQ-006 out_exact SHALL be 1 only when every channel is 8'h00 or 8'hFF.
REQ-007 Decoded results SHALL enter a 2-entry output FIFO; results SHALL leave in acceptance order.
REQ-008 Latency SHALL be 1 cycle: a pixel accepted at edge N SHALL be presented at out_valid=1 after edge N when the FIFO was empty.
REQ-009 An output SHALL be consumed on a rising edge where out_valid=1 and out_ready=1.
REQ-010 out_valid SHALL equal (FIFO count != 0). out_colour and out_exact SHALL show the head entry and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-011 in_ready SHALL equal enable AND (count < 2). It SHALL be derived from registered count only, with no combinational path from out_ready or in_valid.
REQ-012 Push and pop on the same edge SHALL leave count unchanged and preserve ordering.
REQ-013 With count=2, no push SHALL occur. A pop SHALL reduce count to 1 and raise in_ready on the next cycle.
REQ-014 miss_count SHALL increment by 1 for each accepted pixel with out_exact=0, and SHALL saturate at 8'hFF with no wrap.
REQ-015 enable falling while FIFO is non-empty SHALL NOT drop entries; draining SHALL continue.

Reset
REQ-016 While rst_n=0 at an edge, FIFO count SHALL become 0, out_valid=0, out_colour=3'b000, out_exact=0, miss_count=8'h00, and in_ready=0.
REQ-017 Reset mid-operation SHALL discard all buffered pixels; none SHALL appear after rst_n returns high.
REQ-018 in_ready SHALL become enable on the first edge after rst_n is sampled high.

Configuration
REQ-019 Macro DROP_INEXACT_EN SHALL select how non-exact pixels are handled.
REQ-020 With DROP_INEXACT_EN defined:
- an accepted non-exact pixel SHALL be counted in miss_count and SHALL NOT be pushed;
- out_exact SHALL be constant 1.
REQ-021 Without DROP_INEXACT_EN, non-exact pixels SHALL be decoded per REQ-005 and pushed with out_exact=0.

Verification
REQ-022 Bench SHALL cover the following scenarios:
- Reset; then in_rgb=24'h00FFFF, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_colour=3, out_exact=1; miss_count=0.
- Sweep all 8 palette values back-to-back with out_ready=1 -> out_colour sequence 0..7 in order, one per cycle, all out_exact=1.
- in_rgb=24'h80_7F_FF with out_ready=0 -> out_colour=5 held stable, out_exact=0 (or no output with DROP_INEXACT_EN), miss_count=1.
- out_ready=0 with 3 pixels offered -> in_ready=0 after 2 accepted; then out_ready=1 -> outputs in order, third pixel accepted.
- 300 non-exact pixels -> miss_count saturates at 8'hFF.
- 2 pixels buffered, rst_n=0 for 1 cycle -> out_valid=0, miss_count=0; buffered pixels never appear.
